uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing with mid-bit sampling, one-cycle valid/frame_err strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit before stop and the parity_err port.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [2:0] dbg_state_o
);

  localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, rx_s_q, rx_prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       parity_err_q, parity_err_d;
`endif

  // rx_prev resets low so a line held low across reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      sync1_q   <= rx_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      data_q       <= 8'd0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = 8'd0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == HALF_M1) begin
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == BIT_M1) begin
          cnt_d          = 8'd0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == BIT_M1) begin
          cnt_d   = 8'd0;
          par_d   = rx_s_q ^ (^shift_q);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == BIT_M1) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            data_d       = shift_q;
            valid_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_q;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit and the
// received strobes are compared with a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Posedges from driving the start bit to the strobe being visible: 2 sync flops,
  // edge-detect register, half bit to mid-start, then NB full bits to the stop sample.
  localparam int LAT = 3 + HALF + NB * CPB;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cyc = 0;
  logic [7:0] last_data;

  // Scoreboard: strobes observed by the monitor, matched against model expectations.
  logic [7:0] exp_q[$];
  logic [7:0] ev_data_q[$];
  logic [1:0] ev_kind_q[$];
  logic       ev_par_q[$];
  int         ev_cyc_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cyc++;
      if (valid || frame_err) begin
        ev_kind_q.push_back({frame_err, valid});
        ev_data_q.push_back(data);
        ev_cyc_q.push_back(cyc);
`ifdef UART_RX_PARITY_EN
        ev_par_q.push_back(parity_err);
`else
        ev_par_q.push_back(1'b0);
`endif
        checks++;
        if (valid && frame_err) begin
          failures++;
          $display("FAIL strobe_exclusive: valid=%b frame_err=%b at cycle %0d, required not both", valid, frame_err, cyc);
        end
      end
    end
  end

  // Driver tasks
  task automatic sync_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ev_kind_q.delete();
    ev_data_q.delete();
    ev_cyc_q.delete();
    ev_par_q.delete();
    exp_q.delete();
    busy_cyc = 0;
  endtask

  task automatic drive_bit(input logic v, input int len);
    rx_in = v;
    repeat (len) sync_clk();
  endtask

  // Must be entered #1 after a posedge; st is the cycle stamp of the start-bit drive.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbit,
                            input int stop_len, output int st);
    st = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit, CPB);
`else
    if (pbit) rx_in = 1'b1;
`endif
    drive_bit(stop, stop_len);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b0;
    repeat (3) sync_clk();
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h required 00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
`ifdef UART_RX_PARITY_EN
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err: got %b required 0", parity_err); end
`endif
    clear_events();
    rst = 1'b0;
    repeat (40) sync_clk();
    checks++; if (busy_cyc != 0) begin failures++; $display("FAIL low_at_release_busy: busy cycles %0d required 0", busy_cyc); end
    checks++; if (ev_kind_q.size() != 0) begin failures++; $display("FAIL low_at_release_events: got %0d required 0", ev_kind_q.size()); end
    rx_in = 1'b1;
    repeat (10) sync_clk();
    last_data = 8'h00;
  endtask

  task automatic test_single();
    logic [7:0] b;
    int st;
    for (int n = 0; n < 6; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      clear_events();
      exp_q.push_back(b);
      send_frame(b, 1'b1, ^b, CPB, st);
      repeat (10) sync_clk();
      checks++;
      if (ev_kind_q.size() != 1) begin
        failures++; $display("FAIL single_count: byte %h events %0d required 1", b, ev_kind_q.size());
      end else begin
        checks++; if (ev_kind_q[0] !== 2'b01) begin failures++; $display("FAIL single_kind: byte %h kind %b required 01", b, ev_kind_q[0]); end
        checks++; if (ev_data_q[0] !== exp_q[0]) begin failures++; $display("FAIL single_data: got %h required %h", ev_data_q[0], exp_q[0]); end
        checks++; if (ev_cyc_q[0] != st + LAT) begin failures++; $display("FAIL single_latency: byte %h got cycle %0d required %0d", b, ev_cyc_q[0], st + LAT); end
        checks++; if (ev_par_q[0] !== 1'b0) begin failures++; $display("FAIL single_parity: byte %h got %b required 0", b, ev_par_q[0]); end
      end
      checks++; if (data !== b) begin failures++; $display("FAIL single_hold: data %h required %h", data, b); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b required 0", busy); end
      last_data = b;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    int st0, st1, gap;
    for (int n = 0; n < 3; n++) begin
      b0 = (n == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      b1 = (n == 0) ? 8'hC3 : 8'($urandom_range(0, 255));
      // 2*HALF stop cycles puts the next start edge exactly HALF after the stop sample.
      gap = (n == 0) ? 2 * HALF : 2 * HALF + int'($urandom_range(0, 5));
      clear_events();
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      send_frame(b0, 1'b1, ^b0, gap, st0);
      send_frame(b1, 1'b1, ^b1, CPB, st1);
      repeat (10) sync_clk();
      checks++;
      if (ev_kind_q.size() != 2) begin
        failures++; $display("FAIL b2b_count: %h,%h gap %0d events %0d required 2", b0, b1, gap, ev_kind_q.size());
      end else begin
        for (int k = 0; k < 2; k++) begin
          checks++; if (ev_kind_q[k] !== 2'b01) begin failures++; $display("FAIL b2b_kind: frame %0d kind %b required 01", k, ev_kind_q[k]); end
          checks++; if (ev_data_q[k] !== exp_q[k]) begin failures++; $display("FAIL b2b_data: frame %0d got %h required %h", k, ev_data_q[k], exp_q[k]); end
        end
        checks++; if (ev_cyc_q[1] != st1 + LAT) begin failures++; $display("FAIL b2b_latency: got cycle %0d required %0d", ev_cyc_q[1], st1 + LAT); end
      end
      checks++; if (data !== b1) begin failures++; $display("FAIL b2b_hold: data %h required %h", data, b1); end
      last_data = b1;
    end
  endtask

  task automatic test_glitch();
    int lens[3] = '{3, 1, HALF - 2};
    for (int n = 0; n < 3; n++) begin
      clear_events();
      rx_in = 1'b0;
      repeat (lens[n]) sync_clk();
      rx_in = 1'b1;
      repeat (40) sync_clk();
      checks++; if (ev_kind_q.size() != 0) begin failures++; $display("FAIL glitch_events: len %0d got %0d required 0", lens[n], ev_kind_q.size()); end
      checks++; if (busy_cyc != HALF) begin failures++; $display("FAIL glitch_busy: len %0d busy cycles %0d required %0d", lens[n], busy_cyc, HALF); end
      checks++; if (data !== last_data) begin failures++; $display("FAIL glitch_data: got %h required %h", data, last_data); end
    end
  endtask

  task automatic test_frame_err();
    int st;
    clear_events();
    send_frame(8'hFF, 1'b0, 1'b0, CPB + 100, st);
    checks++;
    if (ev_kind_q.size() != 1) begin
      failures++; $display("FAIL ferr_count: events %0d required 1", ev_kind_q.size());
    end else begin
      checks++; if (ev_kind_q[0] !== 2'b10) begin failures++; $display("FAIL ferr_kind: kind %b required 10", ev_kind_q[0]); end
      checks++; if (ev_cyc_q[0] != st + LAT) begin failures++; $display("FAIL ferr_latency: got cycle %0d required %0d", ev_cyc_q[0], st + LAT); end
      checks++; if (ev_par_q[0] !== 1'b0) begin failures++; $display("FAIL ferr_parity: got %b required 0", ev_par_q[0]); end
      checks++; if (ev_data_q[0] !== last_data) begin failures++; $display("FAIL ferr_data_strobe: got %h required %h", ev_data_q[0], last_data); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_busy: got %b required 0", busy); end
    rx_in = 1'b1;
    repeat (20) sync_clk();
    checks++; if (ev_kind_q.size() != 1) begin failures++; $display("FAIL break_no_refire: events %0d required 1", ev_kind_q.size()); end
    checks++; if (data !== last_data) begin failures++; $display("FAIL ferr_data_hold: got %h required %h", data, last_data); end
    clear_events();
    send_frame(8'h96, 1'b1, ^(8'h96), CPB, st);
    repeat (10) sync_clk();
    checks++; if (ev_kind_q.size() != 1 || ev_kind_q[0] !== 2'b01) begin failures++; $display("FAIL after_break_frame: events %0d required one valid", ev_kind_q.size()); end
    checks++; if (data !== 8'h96) begin failures++; $display("FAIL after_break_data: got %h required 96", data); end
    last_data = 8'h96;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int st;
    b = 8'h77;
    clear_events();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
    rx_in = b[4];
    repeat (HALF) sync_clk();
    rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h required 00", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL midrst_strobes: valid %b frame_err %b required 0 0", valid, frame_err); end
    repeat (3) sync_clk();
    rx_in = 1'b1;
    rst = 1'b0;
    repeat (20) sync_clk();
    checks++; if (ev_kind_q.size() != 0) begin failures++; $display("FAIL midrst_discard: events %0d required 0", ev_kind_q.size()); end
    last_data = 8'h00;
    clear_events();
    send_frame(8'h5A, 1'b1, ^(8'h5A), CPB, st);
    repeat (10) sync_clk();
    checks++; if (ev_kind_q.size() != 1) begin failures++; $display("FAIL midrst_next_count: events %0d required 1", ev_kind_q.size()); end
    checks++; if (data !== 8'h5A) begin failures++; $display("FAIL midrst_next_data: got %h required 5a", data); end
    last_data = 8'h5A;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    logic pbit, exp_perr;
    int st;
    for (int n = 0; n < 6; n++) begin
      b    = (n < 2) ? 8'h01 : 8'($urandom_range(0, 255));
      pbit = (n == 0) ? 1'b0 : (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_perr = (^b) ^ pbit;
      clear_events();
      send_frame(b, 1'b1, pbit, CPB, st);
      repeat (10) sync_clk();
      checks++;
      if (ev_kind_q.size() != 1) begin
        failures++; $display("FAIL parity_count: byte %h events %0d required 1", b, ev_kind_q.size());
      end else begin
        checks++; if (ev_kind_q[0] !== 2'b01) begin failures++; $display("FAIL parity_kind: kind %b required 01", ev_kind_q[0]); end
        checks++; if (ev_par_q[0] !== exp_perr) begin failures++; $display("FAIL parity_flag: byte %h pbit %b got %b required %b", b, pbit, ev_par_q[0], exp_perr); end
        checks++; if (ev_data_q[0] !== b) begin failures++; $display("FAIL parity_data: got %h required %h", ev_data_q[0], b); end
      end
      last_data = b;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx_in = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
